// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial adder.
package serial_add_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } serial_add_state_t;

    localparam int SERIAL_ADD_DEFAULT_WIDTH = 8;

endpackage

// File: rtl/serial_add_if.sv
// Request/result bundle for serial_add.
// The ovf signal exists only when SERIAL_ADD_OVF_EN is defined.
interface serial_add_if #(
    parameter int WIDTH = serial_add_pkg::SERIAL_ADD_DEFAULT_WIDTH
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             cout;
`ifdef SERIAL_ADD_OVF_EN
    logic             ovf;

    modport master (output start, a, b, cin, input busy, done, sum, cout, ovf);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout, ovf);
`else
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave  (input start, a, b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/full_add.sv
// Single-bit full adder cell.
module full_add (
    input  logic a,
    input  logic b,
    input  logic c,
    output logic sum,
    output logic carry
);
    assign sum   = a ^ b ^ c;
    assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add.sv
// Bit-serial ripple adder: one full_add cell, LSB first, WIDTH+1 cycles per add.
// Optional signed-overflow output enabled by defining SERIAL_ADD_OVF_EN.
module serial_add
    import serial_add_pkg::*;
#(
    parameter int WIDTH = SERIAL_ADD_DEFAULT_WIDTH
) (
    input logic           clk,
    input logic           rst_n,
    serial_add_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    serial_add_state_t state;
    logic [WIDTH-1:0]  sa;
    logic [WIDTH-1:0]  sb;
    logic [WIDTH-1:0]  sacc;
    logic              carry;
    logic [CW-1:0]     cnt;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  sum_q;
    logic              cout_q;
    logic              fa_sum;
    logic              fa_carry;

    full_add u_fa (
        .a     (sa[0]),
        .b     (sb[0]),
        .c     (carry),
        .sum   (fa_sum),
        .carry (fa_carry)
    );

`ifdef SERIAL_ADD_OVF_EN
    // Carry into the MSB, captured alongside the final carry-out.
    logic cmsb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cmsb <= 1'b0;
        end else if (state == RUN && cnt == LAST) begin
            cmsb <= carry;
        end
    end

    assign bus.ovf = cmsb ^ cout_q;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            sacc   <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        sa     <= bus.a;
                        sb     <= bus.b;
                        carry  <= bus.cin;
                        cnt    <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    carry <= fa_carry;
                    sacc  <= {fa_sum, sacc[WIDTH-1:1]};
                    sa    <= sa >> 1;
                    sb    <= sb >> 1;
                    cnt   <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        sum_q  <= {fa_sum, sacc[WIDTH-1:1]};
                        cout_q <= fa_carry;
                        done_q <= 1'b1;
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.sum  = sum_q;
    assign bus.cout = cout_q;

endmodule

// File: tb/tb_serial_add.sv
// Directed bench for serial_add (WIDTH=8); covers ovf when SERIAL_ADD_OVF_EN is defined.
module tb_serial_add;
    localparam int W = 8;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    serial_add_if #(.WIDTH(W)) bus ();

    serial_add #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Returns number of falling edges until done is seen (bounded).
    task automatic wait_done(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.done && cyc < 20);
    endtask

    task automatic check_ovf(input string tag, input logic exp);
`ifdef SERIAL_ADD_OVF_EN
        chk(tag, {31'd0, bus.ovf}, {31'd0, exp});
`else
        if (exp === 1'bx) $display("unreachable %s", tag);
`endif
    endtask

    task automatic run_add(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic [W-1:0] es, input logic ec,
                           input logic eo);
        int cyc;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = a;
        bus.b     = b;
        bus.cin   = cin;
        @(negedge clk);
        bus.start = 1'b0;
        chk({tag, "_busy"}, {31'd0, bus.busy}, 32'd1);
        wait_done(cyc);
        chk({tag, "_lat"}, cyc + 1, 32'd9);
        chk({tag, "_sum"}, {24'd0, bus.sum}, {24'd0, es});
        chk({tag, "_cout"}, {31'd0, bus.cout}, {31'd0, ec});
        chk({tag, "_nbusy"}, {31'd0, bus.busy}, 32'd0);
        check_ovf({tag, "_ovf"}, eo);
        @(negedge clk);
        chk({tag, "_dpulse"}, {31'd0, bus.done}, 32'd0);
    endtask

    initial begin
        int ndone;
        int t1;
        int t2;
        logic [W-1:0] seen;

        n_chk     = 0;
        n_err     = 0;
        rst_n     = 1'b0;
        bus.start = 1'b0;
        bus.a     = '0;
        bus.b     = '0;
        bus.cin   = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_done", {31'd0, bus.done}, 32'd0);
        chk("rst_sum", {24'd0, bus.sum}, 32'd0);
        chk("rst_cout", {31'd0, bus.cout}, 32'd0);
        check_ovf("rst_ovf", 1'b0);
        rst_n = 1'b1;

        run_add("basic", 8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1);
        run_add("carry", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        run_add("cin", 8'h00, 8'h00, 1'b1, 8'h01, 1'b0, 1'b0);
        run_add("msb", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);

        // Start while busy: second start and operand changes must be ignored.
        @(negedge clk);
        bus.start = 1'b1; bus.a = 8'h10; bus.b = 8'h20; bus.cin = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        ndone = 0;
        seen  = '0;
        for (int i = 0; i < 30; i++) begin
            if (i == 2) begin
                bus.start = 1'b1; bus.a = 8'hFF; bus.b = 8'hFF;
            end else if (i == 3) begin
                bus.start = 1'b0; bus.a = 8'h55;
            end
            if (bus.done) begin
                ndone++;
                seen = bus.sum;
                chk("busy_cout", {31'd0, bus.cout}, 32'd0);
            end
            @(negedge clk);
        end
        chk("busy_ndone", ndone, 32'd1);
        chk("busy_sum", {24'd0, seen}, 32'h30);

        // Back-to-back with start held high.
        bus.start = 1'b1; bus.a = 8'h01; bus.b = 8'h01; bus.cin = 1'b0;
        @(negedge clk);
        ndone = 0; t1 = 0; t2 = 0;
        for (int i = 1; i < 30 && ndone < 2; i++) begin
            chk("b2b_busy", {31'd0, bus.busy}, {31'd0, ~bus.done});
            if (bus.done) begin
                ndone++;
                if (ndone == 1) begin
                    t1 = i;
                    chk("b2b_sum1", {24'd0, bus.sum}, 32'h02);
                    bus.a = 8'h02; bus.b = 8'h02;
                end else begin
                    t2 = i;
                    chk("b2b_sum2", {24'd0, bus.sum}, 32'h04);
                    bus.start = 1'b0;
                end
            end
            @(negedge clk);
        end
        bus.start = 1'b0;
        chk("b2b_ndone", ndone, 32'd2);
        chk("b2b_gap", t2 - t1, 32'd9);
        repeat (12) @(negedge clk);

        // Reset mid-operation.
        bus.start = 1'b1; bus.a = 8'h3C; bus.b = 8'h5A;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (4) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("mrst_done", {31'd0, bus.done}, 32'd0);
        chk("mrst_sum", {24'd0, bus.sum}, 32'd0);
        chk("mrst_cout", {31'd0, bus.cout}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy || bus.sum != 0 || bus.cout) ndone++;
        end
        chk("mrst_quiet", ndone, 32'd0);
        run_add("post", 8'h05, 8'h03, 1'b0, 8'h08, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
